// File: rtl/switch_pulse_sequencer.sv
// switch_pulse_sequencer
// Drives one photonic-switch control line with a programmable burst:
// an optional initial delay, then n_pulses high pulses of on_us ticks
// separated by off_us-tick gaps. All phase lengths are counted in
// en_1MHz ticks while the logic itself runs on the fast system clock.

module switch_pulse_sequencer #(
  parameter int TW = 8,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_1MHz,
  input  logic          start,
  input  logic          abort,
  input  logic [TW-1:0] delay_us,
  input  logic [TW-1:0] on_us,
  input  logic [TW-1:0] off_us,
  input  logic [NW-1:0] n_pulses,
  output logic          sw_out,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] pulse_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_ON    = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [TW-1:0] ONE_T = TW'(1);
  localparam logic [NW-1:0] ONE_N = NW'(1);

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt, tick_cnt_nx;
  logic [NW-1:0] pulse_cnt_nx;
  logic [TW-1:0] lat_delay, lat_on, lat_off;
  logic [TW-1:0] lat_delay_nx, lat_on_nx, lat_off_nx;
  logic [NW-1:0] lat_n, lat_n_nx;
  logic [TW-1:0] phase_len;
  logic          phase_last;
  logic [NW-1:0] pulse_inc;
  logic          accept;

  // Length of the phase currently being timed and whether this tick ends it
  always_comb begin
    phase_len = '0;
    case (state)
      S_DELAY: phase_len = lat_delay;
      S_ON:    phase_len = lat_on;
      S_GAP:   phase_len = lat_off;
      default: phase_len = '0;
    endcase
    phase_last = en_1MHz && (tick_cnt == (phase_len - ONE_T));
    pulse_inc  = pulse_cnt + ONE_N;
    accept     = start && (n_pulses != '0) && (on_us != '0);
  end

  // Next-state, counter and configuration-latch logic; abort has final say
  always_comb begin
    state_nx     = state;
    tick_cnt_nx  = tick_cnt;
    pulse_cnt_nx = pulse_cnt;
    lat_delay_nx = lat_delay;
    lat_on_nx    = lat_on;
    lat_off_nx   = lat_off;
    lat_n_nx     = lat_n;

    case (state)
      S_IDLE: begin
        if (accept) begin
          lat_delay_nx = delay_us;
          lat_on_nx    = on_us;
          lat_off_nx   = off_us;
          lat_n_nx     = n_pulses;
          pulse_cnt_nx = '0;
          tick_cnt_nx  = '0;
          state_nx     = (delay_us != '0) ? S_DELAY : S_ON;
        end
      end

      S_DELAY: begin
        if (en_1MHz) begin
          if (phase_last) begin
            tick_cnt_nx = '0;
            state_nx    = S_ON;
          end else begin
            tick_cnt_nx = tick_cnt + ONE_T;
          end
        end
      end

      S_ON: begin
        if (en_1MHz) begin
          if (phase_last) begin
            tick_cnt_nx  = '0;
            pulse_cnt_nx = pulse_inc;
            if (pulse_inc == lat_n) begin
              state_nx = S_DONE;
            end else if (lat_off != '0) begin
              state_nx = S_GAP;
            end else begin
              state_nx = S_ON;
            end
          end else begin
            tick_cnt_nx = tick_cnt + ONE_T;
          end
        end
      end

      S_GAP: begin
        if (en_1MHz) begin
          if (phase_last) begin
            tick_cnt_nx = '0;
            state_nx    = S_ON;
          end else begin
            tick_cnt_nx = tick_cnt + ONE_T;
          end
        end
      end

      S_DONE: begin
        tick_cnt_nx = '0;
        state_nx    = S_IDLE;
      end

      default: begin
        tick_cnt_nx = '0;
        state_nx    = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_nx     = S_IDLE;
      tick_cnt_nx  = '0;
      pulse_cnt_nx = pulse_cnt;
    end
  end

  // State, counters, latched configuration and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      pulse_cnt <= '0;
      lat_delay <= '0;
      lat_on    <= '0;
      lat_off   <= '0;
      lat_n     <= '0;
      sw_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_cnt_nx;
      pulse_cnt <= pulse_cnt_nx;
      lat_delay <= lat_delay_nx;
      lat_on    <= lat_on_nx;
      lat_off   <= lat_off_nx;
      lat_n     <= lat_n_nx;
      sw_out    <= (state_nx == S_ON);
      busy      <= (state_nx != S_IDLE);
      done      <= (state_nx == S_DONE);
    end
  end

endmodule
